lfsr_pattern_src: RTL and testbench
===================================

Name: lfsr_pattern_src

Overview:
- Hardware pattern source for the gate-level fault-simulation benches; sits directly upstream of the circuit under test and drives its packed input vector.
- Fibonacci LFSR produces NPAT pseudo-random patterns under a valid/ready handshake.
- Optionally compacts the CUT response into a MISR signature, so a bench can compare good-machine and faulty-machine signatures.

Parameters:
- WIDTH, 3, pattern width; matches the CUT packed input vector.
- POLY, 3'b110, feedback tap mask; default is x^3+x^2+1, maximal length.
- SEED, 3'b001, LFSR load value on start; SEED==0 is replaced by 1.
- NPAT, 7, patterns per run, 1..2^WIDTH-1.
- RESP_W, 1, CUT response width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a run; honoured in IDLE or DONE only
- abort  in  1  synchronous return to IDLE
- pat  out  WIDTH  pattern to CUT
- pat_valid  out  1  pat is valid
- pat_ready  in  1  CUT side accepts pat
- pat_idx  out  $clog2(NPAT+1)  index of current pattern
- resp  in  RESP_W  CUT response, sampled on accept
- busy  out  1  high in RUN
- done  out  1  high in DONE
- sig  out  WIDTH  MISR signature

Behaviour:
- Reset: the async assert forces state=IDLE and pat=0, pat_valid=0, pat_idx=0, busy=0, done=0, sig=0.
- Reset applied mid-run discards the run entirely; there is no resume.
- State IDLE:
  - start=1 -> RUN.
  - Next edge loads pat=SEED, pat_idx=0, pat_valid=1, sig=0.
- State RUN:
  - An accept is pat_valid&&pat_ready at a rising edge.
  - On accept with pat_idx<NPAT-1: pat <= {pat[WIDTH-2:0], ^(pat&POLY)} and pat_idx increments.
  - On accept with pat_idx==NPAT-1: -> DONE, pat_valid=0; pat holds its last value.
  - pat_ready=0: pat, pat_idx and sig hold. pat_valid stays 1 and pat must stay stable until accepted.
  - Latency: first pattern valid 1 cycle after start; one pattern per cycle under continuous ready.
- State DONE:
  - done=1, held until exit.
  - start -> RUN with a fresh load, same as from IDLE.
- Abort:
  - abort=1 in any state -> IDLE next edge; pat_valid, busy and done clear.
  - sig and pat_idx hold for inspection.
  - abort has priority over start and over an accept in the same cycle.
- Outputs: busy = (state==RUN); done = (state==DONE).
- start while in RUN is ignored.
- Default sequence: 001,010,101,011,111,110,100. The all-zero pattern is never produced.

Optional Feature:
- Macro: LFSR_PATTERN_SRC_MISR_EN.
- Defined: on each accept, sig <= {sig[WIDTH-2:0], ^(sig&POLY)} ^ zero-extended resp. If RESP_W>WIDTH, the upper resp bits are XOR-folded into sig[0].
- Undefined: no MISR logic is built, sig is tied to 0, and resp is unused. Handshake behaviour is identical either way.

Decomposition:
- Shared package holds:
  - state enum: IDLE, RUN, DONE
  - default POLY/SEED constants per width, 3..8
  - function lfsr_next(cur, poly)
- Natural sub-module: lfsr_step_reg, a WIDTH-bit register with load/enable/poly. It is instantiated once for the pattern LFSR and, under the macro, once for the MISR.

Test Plan:
- Basic run: rst pulse, start, pat_ready=1 -> pat 001,010,101,011,111,110,100 on cycles 1..7, pat_idx 0..6. done=1 from cycle 8; busy low from cycle 8.
- Backpressure: pat_ready=0 for 3 cycles at pat_idx=2 -> pat holds 101 with pat_valid=1. The run completes 3 cycles later than the basic run.
- Abort with start: abort and start together at pat_idx=4 -> IDLE next edge, pat_valid=0, done=0, pat_idx holds 4. A later start restarts at 001.
- Reset and restart: async rst mid-run -> all outputs 0 immediately, without waiting for a clock edge. start from DONE -> new run begins at 001.
- MISR, macro defined: resp=1 for the first 3 accepts then 0 -> final sig=3'b101. With resp=0 throughout, sig=000.
- Macro undefined: same stimulus as the MISR test -> sig=000 throughout, pattern sequence unchanged.

Source files
------------

// File: rtl/lfsr_pattern_src_pkg.sv
// Shared types and helpers for the LFSR pattern source: FSM state, default
// maximal-length taps per width, and the Fibonacci step function.
package lfsr_pattern_src_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } srcState_t;

  localparam int unsigned LFSR_MAX_W = 32;

  // Tap masks for shift-left Fibonacci form, feedback into bit 0.
  localparam logic [7:0] DEFAULT_POLY_W3 = 8'h06;
  localparam logic [7:0] DEFAULT_POLY_W4 = 8'h0C;
  localparam logic [7:0] DEFAULT_POLY_W5 = 8'h14;
  localparam logic [7:0] DEFAULT_POLY_W6 = 8'h30;
  localparam logic [7:0] DEFAULT_POLY_W7 = 8'h60;
  localparam logic [7:0] DEFAULT_POLY_W8 = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED    = 8'h01;

  function automatic logic [LFSR_MAX_W-1:0] defaultPoly(input int unsigned width);
    case (width)
      3:       return LFSR_MAX_W'(DEFAULT_POLY_W3);
      4:       return LFSR_MAX_W'(DEFAULT_POLY_W4);
      5:       return LFSR_MAX_W'(DEFAULT_POLY_W5);
      6:       return LFSR_MAX_W'(DEFAULT_POLY_W6);
      7:       return LFSR_MAX_W'(DEFAULT_POLY_W7);
      default: return LFSR_MAX_W'(DEFAULT_POLY_W8);
    endcase
  endfunction

  // Operands are zero-extended; the caller truncates back to its own width.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] cur,
                                                      input logic [LFSR_MAX_W-1:0] poly);
    return {cur[LFSR_MAX_W-2:0], ^(cur & poly)};
  endfunction

endpackage

// File: rtl/lfsr_pattern_src_step_reg.sv
// lfsr_step_reg: WIDTH-bit register that loads a value or takes one Fibonacci
// step (optionally XOR-injecting a word, which turns it into a MISR stage).
module lfsr_step_reg
  import lfsr_pattern_src_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] loadVal,
  input  logic [WIDTH-1:0] poly,
  input  logic [WIDTH-1:0] inj,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] nextVal;

  assign nextVal = WIDTH'(lfsr_next(LFSR_MAX_W'(q), LFSR_MAX_W'(poly))) ^ inj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= loadVal;
    end else if (en) begin
      q <= nextVal;
    end
  end

endmodule

// File: rtl/lfsr_pattern_src.sv
// LFSR pattern source with valid/ready handshake. Define
// LFSR_PATTERN_SRC_MISR_EN to build the response-compacting MISR on sig.
module lfsr_pattern_src
  import lfsr_pattern_src_pkg::*;
#(
  parameter int unsigned       WIDTH  = 3,
  parameter logic [WIDTH-1:0]  POLY   = WIDTH'(defaultPoly(WIDTH)),
  parameter logic [WIDTH-1:0]  SEED   = WIDTH'(DEFAULT_SEED),
  parameter int unsigned       NPAT   = 7,
  parameter int unsigned       RESP_W = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  output logic [WIDTH-1:0]          pat,
  output logic                      pat_valid,
  input  logic                      pat_ready,
  output logic [$clog2(NPAT+1)-1:0] pat_idx,
  input  logic [RESP_W-1:0]         resp,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          sig
);

  localparam int unsigned      IDX_W    = $clog2(NPAT+1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPAT-1);
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  srcState_t state;
  logic      runLoad;
  logic      accept;
  logic      lastAccept;

  assign accept     = (state == RUN) && pat_valid && pat_ready && !abort;
  assign lastAccept = accept && (pat_idx == LAST_IDX);
  assign runLoad    = !abort && start && (state != RUN);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pat_valid <= 1'b0;
      pat_idx   <= '0;
    end else if (abort) begin
      // pat_idx is deliberately left alone so the abort point can be inspected.
      state     <= IDLE;
      pat_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            pat_valid <= 1'b1;
            pat_idx   <= '0;
          end
        end
        RUN: begin
          if (lastAccept) begin
            state     <= DONE;
            pat_valid <= 1'b0;
          end else if (accept) begin
            pat_idx <= pat_idx + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          pat_valid <= 1'b0;
        end
      endcase
    end
  end

  // The final accept leaves pat on the last pattern rather than stepping past it.
  lfsr_step_reg #(.WIDTH(WIDTH)) uPatLfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (runLoad),
    .en      (accept && !lastAccept),
    .loadVal (SEED_EFF),
    .poly    (POLY),
    .inj     ('0),
    .q       (pat)
  );

`ifdef LFSR_PATTERN_SRC_MISR_EN
  logic [WIDTH-1:0] respFold;

  if (RESP_W > WIDTH) begin : gFold
    assign respFold = resp[WIDTH-1:0] ^ {{(WIDTH-1){1'b0}}, ^resp[RESP_W-1:WIDTH]};
  end else begin : gExt
    assign respFold = WIDTH'(resp);
  end

  lfsr_step_reg #(.WIDTH(WIDTH)) uMisr (
    .clk     (clk),
    .rst     (rst),
    .load    (runLoad),
    .en      (accept),
    .loadVal ('0),
    .poly    (POLY),
    .inj     (respFold),
    .q       (sig)
  );
`else
  logic unusedResp;

  assign unusedResp = ^resp;
  assign sig        = '0;
`endif

endmodule

// File: tb/tb_lfsr_pattern_src.sv
// Scoreboard bench for lfsr_pattern_src: stimulus pushes the expected pattern
// stream per run, a negedge monitor pops and compares on every accept.
module tb_lfsr_pattern_src;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       pat_ready = 1'b0;
  logic [0:0] resp = 1'b0;
  logic [2:0] pat;
  logic       pat_valid;
  logic [2:0] pat_idx;
  logic       busy;
  logic       done;
  logic [2:0] sig;

  lfsr_pattern_src #(
    .WIDTH  (3),
    .POLY   (3'b110),
    .SEED   (3'b001),
    .NPAT   (7),
    .RESP_W (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pat       (pat),
    .pat_valid (pat_valid),
    .pat_ready (pat_ready),
    .pat_idx   (pat_idx),
    .resp      (resp),
    .busy      (busy),
    .done      (done),
    .sig       (sig)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] pat;
    logic [2:0] idx;
  } expT;

  expT        expQ[$];
  int         passCnt = 0;
  int         checkCnt = 0;
  int         defaultSeq[7] = '{1, 2, 5, 3, 7, 6, 4};
  logic [2:0] modelSig = '0;
  int         accCnt = 0;
  int         stallCnt = 0;
  bit         prevStall = 1'b0;
  logic [2:0] heldPat = '0;

`ifdef LFSR_PATTERN_SRC_MISR_EN
  localparam logic [2:0] EXP_SIG_ONES = 3'b101;
`else
  localparam logic [2:0] EXP_SIG_ONES = 3'b000;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Signature register as a shift-with-parity of tapped bits, response XORed in.
  function automatic logic [2:0] misrStep(input logic [2:0] s, input logic r);
    int v;
    v = ((int'(s) << 1) | ($countones(s & 3'b110) % 2)) & 7;
    v = v ^ int'(r);
    return 3'(v);
  endfunction

  task automatic pushRun();
    for (int i = 0; i < 7; i++) begin
      expQ.push_back('{pat: 3'(defaultSeq[i]), idx: 3'(i)});
    end
  endtask

  always @(negedge clk) begin
    if (rst || abort) begin
      prevStall = 1'b0;
    end else if (pat_valid) begin
      if (prevStall) check("stall_hold", 32'(pat), 32'(heldPat));
      if (pat_ready) begin
        if (expQ.size() == 0) begin
          check("accept_queue_depth", 32'(expQ.size()), 32'd1);
        end else begin
          expT e;
          e = expQ.pop_front();
          check("pat", 32'(pat), 32'(e.pat));
          check("pat_idx", 32'(pat_idx), 32'(e.idx));
        end
`ifdef LFSR_PATTERN_SRC_MISR_EN
        modelSig = misrStep(modelSig, resp[0]);
`endif
        accCnt++;
        prevStall = 1'b0;
      end else begin
        stallCnt++;
        prevStall = 1'b1;
        heldPat = pat;
      end
    end else begin
      prevStall = 1'b0;
    end
  end

  // readyMode: 0 always ready, 1 three stall cycles at pat_idx 2, 2 random (with stray starts)
  // respMode:  0 zeros, 1 ones for the first three accepts, 2 random
  task automatic doRun(input int readyMode, input int respMode, output int cycles);
    expQ.delete();
    pushRun();
    modelSig = '0;
    accCnt = 0;
    stallCnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    check("first_valid", 32'(pat_valid), 32'd1);
    check("busy_in_run", 32'(busy), 32'd1);
    while (!done && cycles < 64) begin
      case (readyMode)
        0:       pat_ready = 1'b1;
        1:       pat_ready = !(cycles >= 3 && cycles < 6);
        default: pat_ready = ($urandom_range(0, 3) != 0);
      endcase
      case (respMode)
        0:       resp = 1'b0;
        1:       resp = (accCnt < 3);
        default: resp = 1'($urandom_range(0, 1));
      endcase
      if (readyMode == 2) start = ($urandom_range(0, 5) == 0);
      @(posedge clk); #1;
      cycles++;
      if (readyMode == 1 && cycles == 5) begin
        check("stall_pat", 32'(pat), 32'h5);
        check("stall_valid", 32'(pat_valid), 32'd1);
        check("stall_idx", 32'(pat_idx), 32'd2);
      end
    end
    start = 1'b0;
    pat_ready = 1'b0;
    check("run_length", 32'(cycles), 32'(8 + stallCnt));
    check("done_flag", 32'(done), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
    check("valid_after_done", 32'(pat_valid), 32'd0);
    check("pat_holds_last", 32'(pat), 32'h4);
    check("sig_end", 32'(sig), 32'(modelSig));
    check("queue_drained", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    int c;
    int n;

    #2;
    check("rst_pat", 32'(pat), 32'd0);
    check("rst_valid", 32'(pat_valid), 32'd0);
    check("rst_idx", 32'(pat_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sig", 32'(sig), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    doRun(0, 0, c);
    check("basic_len", 32'(c), 32'd8);
    doRun(1, 0, c);
    check("stall_len", 32'(c), 32'd11);
    doRun(0, 1, c);
    check("misr_sig_ones", 32'(sig), 32'(EXP_SIG_ONES));
    doRun(0, 0, c);
    check("misr_sig_zero", 32'(sig), 32'd0);
    repeat (6) doRun(2, 2, c);

    // abort together with start and a would-be accept at pat_idx 4
    expQ.delete();
    pushRun();
    modelSig = '0;
    accCnt = 0;
    start = 1'b1;
    pat_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (pat_idx != 3'd4 && n < 20) begin
      resp = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    check("abort_reach_idx4", 32'(pat_idx), 32'd4);
    abort = 1'b1;
    start = 1'b1;
    resp = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    check("abort_valid", 32'(pat_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_idx_hold", 32'(pat_idx), 32'd4);
    check("abort_sig_hold", 32'(sig), 32'(modelSig));
    expQ.delete();
    @(posedge clk); #1;
    check("abort_stays_idle", 32'(busy), 32'd0);
    doRun(0, 2, c);

    // asynchronous reset between edges, mid-run
    expQ.delete();
    pushRun();
    start = 1'b1;
    pat_ready = 1'b1;
    resp = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_pat", 32'(pat), 32'd0);
    check("arst_valid", 32'(pat_valid), 32'd0);
    check("arst_idx", 32'(pat_idx), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_sig", 32'(sig), 32'd0);
    expQ.delete();
    pat_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    doRun(0, 2, c);
    check("restart_len", 32'(c), 32'd8);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
